// File: rtl/exibicao_pkg.sv
// ---------------------------------------------------------------------------
// exibicao_pkg
// Shared definitions for the sequence display controller:
//   - FSM state encoding (also driven onto the 7-segment debug output)
//   - default phase durations in clock cycles (1 kHz clock -> ms)
//   - address / LED / phase-counter widths
//   - helper that converts a phase duration into a counter reload value
// ---------------------------------------------------------------------------
package exibicao_pkg;

    localparam int ADDR_W = 4;
    localparam int LED_W  = 4;
    localparam int CONT_W = 16;

    localparam int T_ON_PADRAO  = 500;
    localparam int T_OFF_PADRAO = 499;

    localparam logic [2:0] INICIAL = 3'd0;
    localparam logic [2:0] CARREGA = 3'd1;
    localparam logic [2:0] ACENDE  = 3'd2;
    localparam logic [2:0] APAGA   = 3'd3;
    localparam logic [2:0] PROXIMO = 3'd4;
    localparam logic [2:0] FIM     = 3'd5;

    // The counter is loaded on the phase's first edge and the phase ends on
    // the cycle it reads zero, so a phase of N cycles reloads with N-1.
    function automatic logic [CONT_W-1:0] carga_fase(input int ciclos);
        return CONT_W'(ciclos - 1);
    endfunction

endpackage

// File: rtl/contador_fase.sv
// ---------------------------------------------------------------------------
// contador_fase
// Loadable down-counter used to time the ACENDE and APAGA phases.
// Ports:
//   clock      in  system clock, rising edge
//   reset      in  synchronous active-high reset (count -> 0)
//   carregar_i in  load valor_i on the next edge (has priority over counting)
//   valor_i    in  reload value
//   zero_o     out high while the count is zero
// The count stops at zero until reloaded.
// ---------------------------------------------------------------------------
module contador_fase
    import exibicao_pkg::*;
#(
    parameter int W = CONT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carregar_i,
    input  logic [W-1:0] valor_i,
    output logic         zero_o
);

    logic [W-1:0] cont_q;
    logic [W-1:0] cont_d;

    // Next count: load, otherwise decrement down to zero and hold there.
    always_comb begin
        cont_d = cont_q;
        if (carregar_i) begin
            cont_d = valor_i;
        end else if (cont_q != {W{1'b0}}) begin
            cont_d = cont_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cont_d = cont_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q <= {W{1'b0}};
        end else begin
            cont_q <= cont_d;
        end
    end

    assign zero_o = (cont_q == {W{1'b0}});

endmodule

// File: rtl/controle_exibicao.sv
// ---------------------------------------------------------------------------
// controle_exibicao
// Plays terms 0..limite of a one-hot sequence ROM on four LEDs. Each term is
// fetched (CARREGA), lit for T_ON cycles (ACENDE), followed by a T_OFF-cycle
// tail (APAGA) and, unless it is the last term, an address step (PROXIMO).
// A single FIM cycle pulses fim_exibicao after the last term.
//
// Ports:
//   clock         in  system clock, rising edge
//   reset         in  synchronous active-high reset
//   iniciar       in  start request, honoured only in INICIAL
//   cancelar      in  abort back to INICIAL (ignored in INICIAL)
//   limite[3:0]   in  index of the last term, captured at start
//   dado_memoria  in  one-hot ROM word for endereco (combinational)
//   endereco[3:0] out ROM address of the current term
//   leds[3:0]     out LED drive
//   exibindo      out high outside INICIAL and FIM
//   fim_exibicao  out one-cycle pulse in FIM
//   db_estado     out current state code for the debug display
//
// Build option: GAP_APAGA_EN -- when defined, LEDs are dark during APAGA,
// PROXIMO and CARREGA so two equal consecutive terms are visibly separated;
// when undefined, the last term stays lit until the next ACENDE.
//
// All outputs come straight from registers: leds/exibindo/fim_exibicao are
// computed from the next state so they are valid during the state itself.
// ---------------------------------------------------------------------------
module controle_exibicao
    import exibicao_pkg::*;
#(
    parameter int T_ON  = T_ON_PADRAO,
    parameter int T_OFF = T_OFF_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              cancelar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [LED_W-1:0]  dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [LED_W-1:0]  leds,
    output logic              exibindo,
    output logic              fim_exibicao,
    output logic [3:0]        db_estado
);

    logic [2:0]        estado_q,   estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] lim_q,      lim_d;
    logic [LED_W-1:0]  led_reg_q,  led_reg_d;
    logic [LED_W-1:0]  leds_q,     leds_d;
    logic              exibindo_q, exibindo_d;
    logic              fim_q,      fim_d;

    logic              carga_s;
    logic [CONT_W-1:0] valor_s;
    logic              fase_zero_s;

    contador_fase #(
        .W (CONT_W)
    ) u_contador_fase (
        .clock      (clock),
        .reset      (reset),
        .carregar_i (carga_s),
        .valor_i    (valor_s),
        .zero_o     (fase_zero_s)
    );

    // FSM next state, address/limit/term registers and phase counter reloads.
    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        lim_d      = lim_q;
        led_reg_d  = led_reg_q;
        carga_s    = 1'b0;
        valor_s    = carga_fase(T_ON);

        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    estado_d   = CARREGA;
                    endereco_d = {ADDR_W{1'b0}};
                    lim_d      = limite;
                    // Cleared so CARREGA of term 0 shows dark LEDs, not a
                    // leftover term from the previous run.
                    led_reg_d  = {LED_W{1'b0}};
                end else begin
                    estado_d = INICIAL;
                end
            end
            CARREGA: begin
                led_reg_d = dado_memoria;
                estado_d  = ACENDE;
                carga_s   = 1'b1;
                valor_s   = carga_fase(T_ON);
            end
            ACENDE: begin
                if (fase_zero_s) begin
                    estado_d = APAGA;
                    carga_s  = 1'b1;
                    valor_s  = carga_fase(T_OFF);
                end else begin
                    estado_d = ACENDE;
                end
            end
            APAGA: begin
                if (fase_zero_s) begin
                    if (endereco_q == lim_q) begin
                        estado_d = FIM;
                    end else begin
                        estado_d = PROXIMO;
                    end
                end else begin
                    estado_d = APAGA;
                end
            end
            PROXIMO: begin
                // Only reached when endereco_q < lim_q, so this cannot wrap.
                endereco_d = endereco_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                estado_d   = CARREGA;
            end
            FIM: begin
                estado_d = INICIAL;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase

        if (cancelar && (estado_q != INICIAL)) begin
            estado_d = INICIAL;
            carga_s  = 1'b0;
        end else begin
            carga_s  = carga_s;
        end
    end

    // Output values for the state being entered.
    always_comb begin
        leds_d     = leds_q;
        exibindo_d = (estado_d != INICIAL) && (estado_d != FIM);
        fim_d      = (estado_d == FIM);

        case (estado_d)
            INICIAL: leds_d = {LED_W{1'b0}};
            FIM:     leds_d = {LED_W{1'b0}};
            // led_reg_d is the freshly fetched term on CARREGA->ACENDE.
            ACENDE:  leds_d = led_reg_d;
`ifdef GAP_APAGA_EN
            APAGA:   leds_d = {LED_W{1'b0}};
`else
            APAGA:   leds_d = led_reg_q;
`endif
            CARREGA: leds_d = leds_q;
            PROXIMO: leds_d = leds_q;
            default: leds_d = {LED_W{1'b0}};
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            endereco_q <= {ADDR_W{1'b0}};
            lim_q      <= {ADDR_W{1'b0}};
            led_reg_q  <= {LED_W{1'b0}};
            leds_q     <= {LED_W{1'b0}};
            exibindo_q <= 1'b0;
            fim_q      <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            lim_q      <= lim_d;
            led_reg_q  <= led_reg_d;
            leds_q     <= leds_d;
            exibindo_q <= exibindo_d;
            fim_q      <= fim_d;
        end
    end

    assign endereco     = endereco_q;
    assign leds         = leds_q;
    assign exibindo     = exibindo_q;
    assign fim_exibicao = fim_q;
    assign db_estado    = {1'b0, estado_q};

endmodule
